// File: rtl/fetch_sequencer.sv
// Fetch/issue controller for the 9-bit instruction ROM.
// Owns the PC, issues one instruction at a time, tracks cycles and retirements.
module fetch_sequencer #(
  parameter int PC_WIDTH  = 16,
  parameter int RESET_PC  = 0,
  parameter int LAST_PC   = 34,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [PC_WIDTH-1:0]  pc_out,
  input  logic [8:0]           instr_in,
  output logic [8:0]           ir_out,
  output logic                 ir_valid,
  input  logic                 ex_ready,
  input  logic                 ex_done,
  input  logic                 br_taken,
  input  logic [PC_WIDTH-1:0]  br_target,
  input  logic                 halt_req,
  output logic                 running,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_LAST = PC_WIDTH'(LAST_PC);

  state_t               state;
  state_t               state_nxt;
  logic [PC_WIDTH-1:0]  pc_nxt;
  logic [PC_WIDTH-1:0]  pc_seq;
  logic [PC_WIDTH-1:0]  pc_br;
  logic [8:0]           ir_nxt;
  logic [CNT_WIDTH-1:0] cyc_nxt;
  logic [CNT_WIDTH-1:0] ret_nxt;
  logic                 clr_cnt;

  assign running  = (state == S_FETCH) ||
                    (state == S_ISSUE) ||
                    (state == S_EXEC);
  assign halted   = (state == S_HALT);
  assign ir_valid = (state == S_ISSUE);

  // Sequential advance wraps naturally at 2^PC_WIDTH.
  assign pc_seq = pc_out + PC_WIDTH'(1);
  assign pc_br  = br_taken ? br_target : pc_seq;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_out;
    ir_nxt    = ir_out;
    ret_nxt   = retired_count;
    clr_cnt   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        ir_nxt    = instr_in;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (ex_ready) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (ex_done) begin
          if (~&retired_count)
            ret_nxt = retired_count + CNT_WIDTH'(1);
          priority case (1'b1)
            halt_req: state_nxt = S_HALT;
            (pc_br > PC_LAST): begin
              pc_nxt    = pc_br;
              state_nxt = S_HALT;
            end
            default: begin
              pc_nxt    = pc_br;
              state_nxt = S_FETCH;
            end
          endcase
        end
      end
      S_HALT: begin
        if (start) begin
          pc_nxt    = PC_RST;
          ir_nxt    = 9'd0;
          clr_cnt   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    cyc_nxt = cycle_count;
    if (clr_cnt) begin
      cyc_nxt = '0;
      ret_nxt = '0;
    end else if (running && ~&cycle_count) begin
      cyc_nxt = cycle_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      pc_out        <= PC_RST;
      ir_out        <= 9'd0;
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      state         <= state_nxt;
      pc_out        <= pc_nxt;
      ir_out        <= ir_nxt;
      cycle_count   <= cyc_nxt;
      retired_count <= ret_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: scoreboarded issue stream plus
// reset, stall, branch, halt and PC-wrap scenarios.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ex_ready;
  logic        ex_done;
  logic        br_taken;
  logic [15:0] br_target;
  logic        halt_req;

  logic [15:0] pc0, pc1;
  logic [8:0]  ins0, ins1;
  logic [8:0]  ir0, ir1;
  logic        v0, v1;
  logic        run0, run1;
  logic        hlt0, hlt1;
  logic [15:0] cc0, cc1;
  logic [15:0] rc0, rc1;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [8:0] rom(input logic [15:0] a);
    logic [15:0] t;
    case (a)
      16'd0:   rom = 9'h001;
      16'd1:   rom = 9'h110;
      16'd2:   rom = 9'h01F;
      16'd3:   rom = 9'h171;
      default: begin
        t   = a * 16'd37 + 16'd5;
        rom = t[8:0];
      end
    endcase
  endfunction

  assign ins0 = rom(pc0);
  assign ins1 = rom(pc1);

  fetch_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start),
    .pc_out(pc0), .instr_in(ins0),
    .ir_out(ir0), .ir_valid(v0),
    .ex_ready(ex_ready), .ex_done(ex_done),
    .br_taken(br_taken), .br_target(br_target),
    .halt_req(halt_req),
    .running(run0), .halted(hlt0),
    .cycle_count(cc0), .retired_count(rc0)
  );

  fetch_sequencer #(.LAST_PC(65535)) u_wrap (
    .clk(clk), .reset(reset), .start(start),
    .pc_out(pc1), .instr_in(ins1),
    .ir_out(ir1), .ir_valid(v1),
    .ex_ready(ex_ready), .ex_done(ex_done),
    .br_taken(br_taken), .br_target(br_target),
    .halt_req(halt_req),
    .running(run1), .halted(hlt1),
    .cycle_count(cc1), .retired_count(rc1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to(input logic [15:0] target);
    int n = 0;
    while (pc0 !== target && n < 400) begin
      step();
      n++;
    end
    n_vec++;
    if (pc0 !== target) begin
      n_err++;
      $display("FAIL run_to: pc_out=%0d required %0d", pc0, target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    ex_ready = 1'b1;
    ex_done  = 1'b1;
    kick();
    run_to(16'd5);
    ex_done = 1'b0;
    step();
    step();
    step();
    n_vec++;
    if (!(run0 && !v0 && pc0 == 16'd5)) begin
      n_err++;
      $display("FAIL pre_reset_exec: run=%b v=%b pc=%0d required 1 0 5",
               run0, v0, pc0);
    end
    do_reset();
    n_vec++;
    if ({pc0, ir0, v0, run0, hlt0} !== {16'd0, 9'd0, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: pc=%0d ir=%h v=%b run=%b hlt=%b",
               pc0, ir0, v0, run0, hlt0);
    end
    n_vec++;
    if (cc0 !== 16'd0 || rc0 !== 16'd0) begin
      n_err++;
      $display("FAIL reset_counters: cyc=%0d ret=%0d required 0 0",
               cc0, rc0);
    end
    ex_done = 1'b1;
  endtask

  task automatic test_sequential();
    int n = 0;
    logic [8:0] e;
    do_reset();
    for (int a = 0; a <= 34; a++) exp_q.push_back(rom(16'(a)));
    kick();
    while (!hlt0 && n < 300) begin
      if (v0) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        n_vec++;
        if (ir0 !== e) begin
          n_err++;
          $display("FAIL seq_ir: pc=%0d ir_out=%h required %h", pc0, ir0, e);
        end
      end
      step();
      n++;
    end
    n_vec++;
    if (!hlt0 || run0 || pc0 !== 16'd35) begin
      n_err++;
      $display("FAIL seq_halt: hlt=%b run=%b pc=%0d required 1 0 35",
               hlt0, run0, pc0);
    end
    n_vec++;
    if (rc0 !== 16'd35 || cc0 !== 16'd105) begin
      n_err++;
      $display("FAIL seq_counts: ret=%0d cyc=%0d required 35 105", rc0, cc0);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL seq_drain: %0d left, required 0", exp_q.size());
      exp_q.delete();
    end
    step();
    n_vec++;
    if (!hlt0 || cc0 !== 16'd105) begin
      n_err++;
      $display("FAIL halt_hold: hlt=%b cyc=%0d required 1 105", hlt0, cc0);
    end
  endtask

  task automatic test_stall();
    logic [15:0] c;
    logic [8:0]  e;
    do_reset();
    ex_ready = 1'b0;
    exp_q.push_back(rom(16'd0));
    kick();
    step();
    c = cc0;
    e = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (!v0 || ir0 !== e || pc0 !== 16'd0) begin
        n_err++;
        $display("FAIL stall_%0d: v=%b ir=%h pc=%0d required 1 %h 0",
                 i, v0, ir0, pc0, e);
      end
    end
    n_vec++;
    if (cc0 !== c + 16'd4) begin
      n_err++;
      $display("FAIL stall_cycles: cyc=%0d required %0d", cc0, c + 16'd4);
    end
    ex_ready = 1'b1;
    step();
    n_vec++;
    if (v0 || !run0) begin
      n_err++;
      $display("FAIL stall_accept: v=%b run=%b required 0 1", v0, run0);
    end
  endtask

  task automatic test_branch();
    do_reset();
    ex_ready = 1'b1;
    ex_done  = 1'b1;
    kick();
    run_to(16'd7);
    br_taken  = 1'b1;
    br_target = 16'd3;
    step();
    step();
    step();
    br_taken = 1'b0;
    exp_q.push_back(rom(16'd3));
    n_vec++;
    if (pc0 !== 16'd3 || !run0) begin
      n_err++;
      $display("FAIL br_pc: pc=%0d run=%b required 3 1", pc0, run0);
    end
    step();
    n_vec++;
    if (!v0 || ir0 !== exp_q.pop_front()) begin
      n_err++;
      $display("FAIL br_ir: v=%b ir_out=%h required 1 171", v0, ir0);
    end
    br_taken  = 1'b1;
    br_target = 16'd40;
    step();
    step();
    br_taken = 1'b0;
    n_vec++;
    if (!hlt0 || pc0 !== 16'd40) begin
      n_err++;
      $display("FAIL br_oob: hlt=%b pc=%0d required 1 40", hlt0, pc0);
    end
  endtask

  task automatic test_halt_req();
    logic [15:0] r;
    do_reset();
    kick();
    run_to(16'd10);
    halt_req  = 1'b1;
    br_taken  = 1'b1;
    br_target = 16'd3;
    r = rc0;
    step();
    step();
    step();
    halt_req = 1'b0;
    br_taken = 1'b0;
    n_vec++;
    if (!hlt0 || pc0 !== 16'd10 || rc0 !== r + 16'd1) begin
      n_err++;
      $display("FAIL halt_req: hlt=%b pc=%0d ret=%0d required 1 10 %0d",
               hlt0, pc0, rc0, r + 16'd1);
    end
    kick();
    n_vec++;
    if (pc0 !== 16'd0 || cc0 !== 16'd0 || rc0 !== 16'd0 ||
        ir0 !== 9'd0 || !run0 || hlt0 || v0) begin
      n_err++;
      $display("FAIL restart: pc=%0d cyc=%0d ret=%0d ir=%h run=%b hlt=%b",
               pc0, cc0, rc0, ir0, run0, hlt0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    br_taken  = 1'b1;
    br_target = 16'hFFFF;
    kick();
    step();
    step();
    step();
    br_taken = 1'b0;
    n_vec++;
    if (pc1 !== 16'hFFFF || hlt1) begin
      n_err++;
      $display("FAIL wrap_setup: pc=%h hlt=%b required ffff 0", pc1, hlt1);
    end
    step();
    step();
    step();
    n_vec++;
    if (pc1 !== 16'd0 || hlt1 || !run1 || v1) begin
      n_err++;
      $display("FAIL wrap: pc=%h hlt=%b run=%b required 0000 0 1",
               pc1, hlt1, run1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    ex_ready  = 1'b1;
    ex_done   = 1'b1;
    br_taken  = 1'b0;
    br_target = 16'd0;
    halt_req  = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_halt_req();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle fetch/issue controller for the 9-bit instruction ROM.
- Owns the program counter and drives the ROM address.
- Latches the returned instruction into an instruction register and issues it to the datapath with a valid/ready handshake.
- Waits for execute completion, applies branch redirects, detects end-of-program/halt, and keeps cycle and retired-instruction counters for the testbench and top level.

Parameters:
PC_WIDTH, 16, width of program counter / ROM address.
RESET_PC, 0, PC loaded at reset and on restart.
LAST_PC, 34, highest valid ROM address; sequential advance or branch beyond it halts.
CNT_WIDTH, 16, width of cycle and retired counters.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin/restart execution (sampled in IDLE and HALT only).
pc_out  output  PC_WIDTH  ROM address (drives ROM pc_in).
instr_in  input  9  ROM word {format, immediate[7:0]}; combinational from pc_out.
ir_out  output  9  latched instruction issued to datapath.
ir_valid  output  1  ir_out valid, awaiting acceptance.
ex_ready  input  1  datapath accepts ir_out this cycle.
ex_done  input  1  datapath finished the accepted instruction.
br_taken  input  1  redirect PC on completion (sampled with ex_done).
br_target  input  PC_WIDTH  redirect address.
halt_req  input  1  datapath requests halt (sampled with ex_done).
running  output  1  state is FETCH, ISSUE or EXEC.
halted  output  1  state is HALT.
cycle_count  output  CNT_WIDTH  cycles spent running.
retired_count  output  CNT_WIDTH  instructions completed.

Behaviour:
- All state registers update on the rising clk edge.
- Reset (any state, including mid-instruction) takes priority over every other input:
  - state=IDLE, pc_out=RESET_PC, ir_out=0, ir_valid=0.
  - running=0, halted=0, both counters=0.
- States:
  - IDLE: outputs hold. start=1 -> FETCH.
  - FETCH (one cycle): ir_out <= instr_in (ROM read at current pc_out). Next state ISSUE.
  - ISSUE: ir_valid=1; ir_out held stable.
    - ex_ready=1 -> handshake; ir_valid drops next cycle; -> EXEC.
    - ex_ready=0 -> remain in ISSUE indefinitely.
  - EXEC: ir_valid=0; wait for ex_done. On ex_done=1:
    - retired_count increments (saturating).
    - halt_req=1 -> HALT; pc_out unchanged. halt_req has priority over br_taken.
    - else next_pc = br_taken ? br_target : pc_out+1, computed modulo 2^PC_WIDTH, so 0xFFFF wraps to 0.
    - pc_out <= next_pc.
    - next_pc > LAST_PC -> HALT; pc_out shows the offending address.
    - else -> FETCH.
  - HALT: halted=1. start=1 -> pc_out=RESET_PC, both counters cleared, ir_out=0, -> FETCH.
- ex_done is ignored outside EXEC. ex_ready is ignored outside ISSUE. start is ignored in FETCH/ISSUE/EXEC.
- cycle_count increments (saturating at all-ones) every cycle running=1.
- Best-case instruction latency: 3 cycles (FETCH, ISSUE with ex_ready=1, EXEC with ex_done=1).
- running and halted are decoded from the state register, never both 1.

Test Plan:
- Reset held 2 cycles mid-EXEC at pc_out=5 -> next cycle: pc_out=0, ir_valid=0, counters=0, running=0, halted=0.
- start pulse, ex_ready=1 and ex_done=1 always, no branch/halt -> ir_out sequence 0x001, 0x110, 0x01F, ... matches ROM addresses 0,1,2.
  - After address 34 completes, pc_out=35, halted=1.
  - retired_count=35; cycle_count=105.
- ex_ready held 0 for 4 cycles in ISSUE -> ir_valid stays 1 and ir_out stays stable all 4 cycles; pc_out unchanged; cycle_count advances by 4.
- At pc_out=7, ex_done with br_taken=1, br_target=3 -> next FETCH reads address 3 (ir_out=0x171).
  - br_target=40 -> HALT with pc_out=40.
- At pc_out=10, ex_done with halt_req=1 and br_taken=1 -> HALT, pc_out=10, retired_count incremented once.
  - Then start=1 -> pc_out=0, counters 0, FETCH.
- LAST_PC=0xFFFF, pc_out=0xFFFF, ex_done, no branch -> pc_out wraps to 0, state FETCH, not halted.
